// File: rtl/messbauer_measurement_sequencer.sv
// ---------------------------------------------------------------------------
// messbauer_measurement_sequencer
//
// Run controller for one Mossbauer test channel. A run request holds the
// channel's generator / saw-tooth / discriminator blocks in reset for
// RESET_CYCLES cycles and then releases them. The controller waits for the
// first start pulse from the generator, then counts channel pulses per frame
// and frames per run, and opens the discriminator gate while running.
// A run ends on:
//   - the frame quota being reached,
//   - a stop command, or
//   - the watchdog expiring.
// Frame-integrity problems raise a sticky error flag.
//
// Ports:
//   aclk              system clock
//   reset             synchronous active-high reset
//   cmd_start         one-cycle run request (ignored while busy)
//   cmd_stop          one-cycle abort request (ignored while idle/done)
//   frames_requested  frames per run, captured at run start; 0 = continuous
//   start             generator start level, rising edge = frame boundary
//   channel           generator channel level, rising edge = channel advance
//   datapath_areset_n active-low reset to the channel datapath blocks
//   gate_enable       enables discriminator threshold outputs (RUN only)
//   busy              run in progress (RESET_PULSE, ARM, RUN)
//   done              run finished by quota or watchdog
//   error             sticky frame/overflow/watchdog error
//   frame_count       completed frames in current/last run
//   channel_index     channel edges counted in the current frame
// ---------------------------------------------------------------------------
module messbauer_measurement_sequencer #(
    parameter int CHANNEL_NUMBER  = 512,
    parameter int RESET_CYCLES    = 16,
    parameter int WATCHDOG_CYCLES = 1048576,
    parameter int CH_W            = 13
) (
    input  logic            aclk,
    input  logic            reset,
    input  logic            cmd_start,
    input  logic            cmd_stop,
    input  logic [15:0]     frames_requested,
    input  logic            start,
    input  logic            channel,
    output logic            datapath_areset_n,
    output logic            gate_enable,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [15:0]     frame_count,
    output logic [CH_W-1:0] channel_index
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_RESET_PULSE = 3'd1,
        S_ARM         = 3'd2,
        S_RUN         = 3'd3,
        S_DONE        = 3'd4
    } state_t;

    localparam logic [CH_W-1:0] CH_FULL  = CH_W'(CHANNEL_NUMBER);
    localparam logic [23:0]     RST_LAST = 24'(RESET_CYCLES - 1);
    localparam logic [23:0]     WD_LAST  = 24'(WATCHDOG_CYCLES - 1);

    state_t          state_q, state_d;
    logic [15:0]     quota_q, quota_d;
    logic            error_q, error_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [CH_W-1:0] channel_index_q, channel_index_d;
    // Shared timer: reset-pulse length in RESET_PULSE, idle-input watchdog in ARM/RUN.
    logic [23:0]     timer_q, timer_d;
    logic            start_r_q, channel_r_q;
    logic            areset_n_q, areset_n_d;
    logic            gate_q, gate_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            st_edge_s;
    logic            ch_edge_s;
    logic [CH_W-1:0] ch_sum_s;
    logic            ch_ovf_s;
    logic [15:0]     frame_inc_s;

    assign st_edge_s = start & ~start_r_q;
    assign ch_edge_s = channel & ~channel_r_q;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d         = state_q;
        quota_d         = quota_q;
        error_d         = error_q;
        frame_count_d   = frame_count_q;
        channel_index_d = channel_index_q;
        timer_d         = timer_q;
        frame_inc_s     = frame_count_q + 16'd1;

        // Channel count including this cycle's edge; saturates at a full frame.
        ch_sum_s = channel_index_q;
        ch_ovf_s = 1'b0;
        if (ch_edge_s) begin
            if (channel_index_q == CH_FULL) begin
                ch_ovf_s = 1'b1;
            end else begin
                ch_sum_s = channel_index_q + CH_W'(1);
            end
        end else begin
            ch_sum_s = channel_index_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cmd_start) begin
                    state_d         = S_RESET_PULSE;
                    quota_d         = frames_requested;
                    error_d         = 1'b0;
                    frame_count_d   = 16'd0;
                    channel_index_d = {CH_W{1'b0}};
                    timer_d         = 24'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RESET_PULSE: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                    timer_d = 24'd0;
                end else if (timer_q == RST_LAST) begin
                    state_d = S_ARM;
                    timer_d = 24'd0;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            S_ARM: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                    timer_d = 24'd0;
                end else if (st_edge_s) begin
                    state_d         = S_RUN;
                    channel_index_d = {CH_W{1'b0}};
                    frame_count_d   = 16'd0;
                    timer_d         = 24'd0;
                end else if (ch_edge_s) begin
                    // Channel edges before the first frame only feed the watchdog.
                    timer_d = 24'd0;
                end else if (timer_q == WD_LAST) begin
                    state_d = S_DONE;
                    error_d = 1'b1;
                    timer_d = 24'd0;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            S_RUN: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                    timer_d = 24'd0;
                end else if (st_edge_s) begin
                    // A coincident channel edge belongs to the frame being closed.
                    error_d         = error_q | ch_ovf_s | (ch_sum_s != CH_FULL);
                    frame_count_d   = frame_inc_s;
                    channel_index_d = {CH_W{1'b0}};
                    timer_d         = 24'd0;
                    if ((quota_q != 16'd0) && (frame_inc_s == quota_q)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (ch_edge_s) begin
                    error_d         = error_q | ch_ovf_s;
                    channel_index_d = ch_sum_s;
                    timer_d         = 24'd0;
                end else if (timer_q == WD_LAST) begin
                    state_d = S_DONE;
                    error_d = 1'b1;
                    timer_d = 24'd0;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 24'd0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same edge.
        areset_n_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DONE);
        gate_d     = (state_d == S_RUN);
        busy_d     = (state_d == S_RESET_PULSE) || (state_d == S_ARM) || (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
    end

    // State, counters, edge history and output registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            quota_q         <= 16'd0;
            error_q         <= 1'b0;
            frame_count_q   <= 16'd0;
            channel_index_q <= {CH_W{1'b0}};
            timer_q         <= 24'd0;
            start_r_q       <= 1'b0;
            channel_r_q     <= 1'b0;
            areset_n_q      <= 1'b0;
            gate_q          <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            quota_q         <= quota_d;
            error_q         <= error_d;
            frame_count_q   <= frame_count_d;
            channel_index_q <= channel_index_d;
            timer_q         <= timer_d;
            start_r_q       <= start;
            channel_r_q     <= channel;
            areset_n_q      <= areset_n_d;
            gate_q          <= gate_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign datapath_areset_n = areset_n_q;
    assign gate_enable       = gate_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign frame_count       = frame_count_q;
    assign channel_index     = channel_index_q;

endmodule

// File: doc/messbauer_measurement_sequencer.md
Name: messbauer_measurement_sequencer

Overview:
Run controller for one Mossbauer test channel (v1 or v2 side). On command it holds the channel's generator, saw-tooth and discriminator-signal blocks in reset for a fixed number of cycles, then releases them. It locks onto the generator's start/channel pulses, counts channels per frame and frames per run, and gates the discriminator outputs. Runs stop on frame quota, stop command or watchdog expiry, and frame-integrity errors are flagged. One instance sits beside each generator at top level and replaces the ad-hoc reset counter.

Parameters:
CHANNEL_NUMBER, 512, expected channel pulses per frame (between consecutive start edges); power of two, 2..4096
RESET_CYCLES, 16, cycles datapath_areset_n is held low after cmd_start; >=1
WATCHDOG_CYCLES, 1048576, max cycles without any start/channel edge while ARM/RUN; <2^24
CH_W, 13, width of channel_index; must hold CHANNEL_NUMBER

Ports:
aclk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
cmd_start  in  1  one-cycle run request
cmd_stop  in  1  one-cycle abort request
frames_requested  in  16  frames per run, sampled on accepted cmd_start; 0 = continuous
start  in  1  generator start level; rising edge = frame boundary
channel  in  1  generator channel level; rising edge = channel advance
datapath_areset_n  out  1  active-low reset to generator/saw-tooth/discriminator blocks
gate_enable  out  1  high only in RUN; enables threshold outputs
busy  out  1  high in RESET_PULSE, ARM, RUN
done  out  1  high in DONE
error  out  1  sticky frame/overflow/watchdog error, cleared on accepted cmd_start
frame_count  out  16  completed frames in current/last run
channel_index  out  CH_W  channel edges counted in current frame

Behaviour:
- Reset (synchronous, takes effect at the next aclk edge, any state): state=IDLE; datapath_areset_n=0, gate_enable=0, busy=0, done=0, error=0, frame_count=0, channel_index=0, edge-detect history=0, timers=0.
- All outputs are registered. Edge detect: start_r/channel_r are 1-cycle delayed copies. An edge is in & ~in_r, so edges are acted on 1 cycle after the input rises.
- States: IDLE, RESET_PULSE, ARM, RUN, DONE.
- IDLE: datapath_areset_n=0. cmd_start -> RESET_PULSE; latch frames_requested; clear error, frame_count, channel_index, reset timer.
- RESET_PULSE: datapath_areset_n=0 for exactly RESET_CYCLES cycles, then -> ARM with datapath_areset_n=1 on the same edge.
- ARM: wait for a start edge. Channel edges are ignored. A start edge -> RUN, with channel_index=0 and frame_count=0.
- RUN: gate_enable=1.
  - Channel edge: channel_index+1. If channel_index is already CHANNEL_NUMBER, the edge sets error and channel_index holds (saturates).
  - Start edge closes the frame. If channel_index != CHANNEL_NUMBER, set error. frame_count+1 (wraps at 2^16 in continuous mode). channel_index=0.
  - If the latched quota != 0 and the new frame_count == quota -> DONE; otherwise stay in RUN.
- Simultaneous start and channel edge in the same cycle: the channel edge is counted into the closing frame first, then the frame check runs, then channel_index=0.
- Watchdog: a counter in ARM/RUN resets on any start or channel edge. On reaching WATCHDOG_CYCLES: set error and -> DONE.
- cmd_stop in RESET_PULSE/ARM/RUN -> IDLE next cycle. done stays 0. error, frame_count and channel_index hold their values. cmd_stop is ignored in IDLE/DONE.
- DONE: datapath_areset_n=1, gate_enable=0, done=1, counters frozen. cmd_start -> RESET_PULSE (same actions as from IDLE).
- cmd_start is ignored while busy. If cmd_start and cmd_stop are asserted together, cmd_stop wins when busy and cmd_start wins otherwise.
- reset while in RUN: datapath_areset_n drops to 0 at the same edge that clears the state.

Test Plan:
- Reset then cmd_start, frames_requested=2, ideal generator (512 channel edges/frame) -> datapath_areset_n low exactly 16 cycles; gate_enable rises 1 cycle after the first start edge; DONE after the 3rd start edge with frame_count=2, error=0.
- Frame with only 511 channel edges before the next start -> error=1 one cycle after that start edge; run continues; frame_count increments.
- 513 channel edges in one frame -> error=1 on the 513th; channel_index stays 512.
- Start and channel rising on the same cycle at channel 511 -> frame closes with 512 counted, no error, channel_index=0.
- Inputs frozen in RUN with WATCHDOG_CYCLES=64 -> error=1 and done=1 exactly 64 cycles after the last edge.
- cmd_stop in RUN, then reset mid-RESET_PULSE -> IDLE; all outputs return to reset values on the next edge; a subsequent cmd_start clears error and restarts the 16-cycle pulse.
